// File: rtl/alu_arbiter.sv
// Purpose: round-robin sequencer sharing one combinational 4-bit ALU between two requesters.
// Latency: gnt one edge after req, done SETTLE_CYCLES edges after gnt (one edge for illegal ops).
// Backpressure: requests are ignored while busy; a held request is re-arbitrated on return to IDLE.
module alu_arbiter #(
  // Edges the ALU inputs are held before the result is captured (1..15).
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       req0,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] op0,
  input  logic       req1,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  input  logic [3:0] op1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [3:0] rdata,
  output logic       rovf,
  output logic       err,
  output logic       busy,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [3:0] alu_result,
  input  logic       alu_overflow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    REJECT = 2'd2
  } state_t;

  // Highest accepted opcode; larger opcodes complete with err set.
  localparam logic [3:0] LAST_LEGAL_OP = 4'b1100;
  // Counter value on which the settled ALU output is captured.
  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);
  // ALU opcode driven while no operation has been issued; the ALU idles at 0.
  localparam logic [3:0] IDLE_OP = 4'b1111;

  state_t     state;
  logic [3:0] cnt;
  logic       owner;
  logic       last_gnt;

  logic       any_req;
  logic       win;
  logic [3:0] win_a;
  logic [3:0] win_b;
  logic [3:0] win_op;
  logic       win_legal;

  // Round-robin pick: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    any_req = req0 | req1;
    win     = 1'b0;
    if (req0 && req1) begin
      win = ~last_gnt;
    end else if (req1) begin
      win = 1'b1;
    end
    win_a     = win ? a1  : a0;
    win_b     = win ? b1  : b0;
    win_op    = win ? op1 : op0;
    win_legal = (win_op <= LAST_LEGAL_OP);
  end

  // Sequencer: grant, hold operands for the settle time, capture and report completion.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      owner    <= 1'b0;
      last_gnt <= 1'b1;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      busy     <= 1'b0;
      rdata    <= 4'd0;
      rovf     <= 1'b0;
      err      <= 1'b0;
      alu_a    <= 4'd0;
      alu_b    <= 4'd0;
      alu_op   <= IDLE_OP;
    end else begin
      // Handshake pulses last exactly one cycle unless re-asserted below.
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;

      case (state)
        IDLE: begin
          if (any_req) begin
            gnt0     <= ~win;
            gnt1     <= win;
            owner    <= win;
            last_gnt <= win;
            busy     <= 1'b1;
            if (win_legal) begin
              alu_a  <= win_a;
              alu_b  <= win_b;
              alu_op <= win_op;
              cnt    <= 4'd0;
              state  <= ISSUE;
            end else begin
              // ALU drive is left untouched for a rejected opcode.
              state <= REJECT;
            end
          end
        end

        ISSUE: begin
          if (cnt == CNT_LAST) begin
            rdata <= alu_result;
            rovf  <= alu_overflow;
            err   <= 1'b0;
            done0 <= ~owner;
            done1 <= owner;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        REJECT: begin
          rdata <= 4'd0;
          rovf  <= 1'b0;
          err   <= 1'b1;
          done0 <= ~owner;
          done1 <= owner;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (settle 1 and settle 3) each driving a bench ALU.
// A cycle-stamped transaction model predicts every output each cycle; directed tests pin it.
// Inputs change 2 time units after the rising edge; outputs are compared on the falling edge.
module tb_alu_arbiter;

  logic       clock;
  logic       rst;
  logic       req0 [2];
  logic       req1 [2];
  logic [3:0] a0 [2];
  logic [3:0] b0 [2];
  logic [3:0] op0 [2];
  logic [3:0] a1 [2];
  logic [3:0] b1 [2];
  logic [3:0] op1 [2];
  logic       gnt0 [2];
  logic       gnt1 [2];
  logic       done0 [2];
  logic       done1 [2];
  logic [3:0] rdata [2];
  logic       rovf [2];
  logic       err [2];
  logic       busy [2];
  logic [3:0] alu_a [2];
  logic [3:0] alu_b [2];
  logic [3:0] alu_op [2];
  logic [3:0] alu_res [2];
  logic       alu_ovf [2];

  int checks = 0;
  int errors = 0;

  // Reference ALU: returns {overflow, result}; signed overflow for add/sub.
  function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    logic [3:0] r;
    logic       v;
    r = 4'd0;
    v = 1'b0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: begin r = a - b; v = (a[3] != b[3]) && (r[3] != a[3]); end
      4'd3: begin r = a + b; v = (a[3] == b[3]) && (r[3] != a[3]); end
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = a << 1;
      4'd7: r = a >> 1;
      4'd8: r = a + 4'd1;
      4'd9: r = a - 4'd1;
      4'd10: r = b;
      4'd11: r = a;
      4'd12: r = ~(a & b);
      default: r = 4'd0;
    endcase
    return {v, r};
  endfunction

  assign {alu_ovf[0], alu_res[0]} = alu_fn(alu_a[0], alu_b[0], alu_op[0]);
  assign {alu_ovf[1], alu_res[1]} = alu_fn(alu_a[1], alu_b[1], alu_op[1]);

  alu_arbiter #(.SETTLE_CYCLES(1)) dut_s1 (
    .clock(clock), .rst(rst),
    .req0(req0[0]), .a0(a0[0]), .b0(b0[0]), .op0(op0[0]),
    .req1(req1[0]), .a1(a1[0]), .b1(b1[0]), .op1(op1[0]),
    .gnt0(gnt0[0]), .gnt1(gnt1[0]), .done0(done0[0]), .done1(done1[0]),
    .rdata(rdata[0]), .rovf(rovf[0]), .err(err[0]), .busy(busy[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_op(alu_op[0]),
    .alu_result(alu_res[0]), .alu_overflow(alu_ovf[0])
  );

  alu_arbiter #(.SETTLE_CYCLES(3)) dut_s3 (
    .clock(clock), .rst(rst),
    .req0(req0[1]), .a0(a0[1]), .b0(b0[1]), .op0(op0[1]),
    .req1(req1[1]), .a1(a1[1]), .b1(b1[1]), .op1(op1[1]),
    .gnt0(gnt0[1]), .gnt1(gnt1[1]), .done0(done0[1]), .done1(done1[1]),
    .rdata(rdata[1]), .rovf(rovf[1]), .err(err[1]), .busy(busy[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_op(alu_op[1]),
    .alu_result(alu_res[1]), .alu_overflow(alu_ovf[1])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- transaction model ----------------
  int         cyc = 0;
  logic       m_busy [2];
  logic       m_owner [2];
  logic       m_last [2];
  logic       m_rej [2];
  int         m_done_at [2];
  logic       e_gnt0 [2];
  logic       e_gnt1 [2];
  logic       e_done0 [2];
  logic       e_done1 [2];
  logic [3:0] e_rdata [2];
  logic       e_rovf [2];
  logic       e_err [2];
  logic [3:0] e_a [2];
  logic [3:0] e_b [2];
  logic [3:0] e_op [2];

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic void model_reset(input int i);
    m_busy[i] = 1'b0; m_owner[i] = 1'b0; m_last[i] = 1'b1; m_rej[i] = 1'b0; m_done_at[i] = -1;
    e_gnt0[i] = 1'b0; e_gnt1[i] = 1'b0; e_done0[i] = 1'b0; e_done1[i] = 1'b0;
    e_rdata[i] = 4'd0; e_rovf[i] = 1'b0; e_err[i] = 1'b0;
    e_a[i] = 4'd0; e_b[i] = 4'd0; e_op[i] = 4'hF;
  endfunction

  function automatic void model_step(input int i);
    logic       w;
    logic [3:0] wo;
    logic [4:0] r;
    e_gnt0[i] = 1'b0; e_gnt1[i] = 1'b0; e_done0[i] = 1'b0; e_done1[i] = 1'b0;
    if (!m_busy[i]) begin
      if (req0[i] || req1[i]) begin
        w = (req0[i] && req1[i]) ? !m_last[i] : req1[i];
        m_last[i] = w; m_owner[i] = w; m_busy[i] = 1'b1;
        e_gnt0[i] = !w; e_gnt1[i] = w;
        wo = w ? op1[i] : op0[i];
        if (wo > 4'd12) begin
          m_rej[i] = 1'b1;
          m_done_at[i] = cyc + 1;
        end else begin
          m_rej[i] = 1'b0;
          e_a[i] = w ? a1[i] : a0[i];
          e_b[i] = w ? b1[i] : b0[i];
          e_op[i] = wo;
          m_done_at[i] = cyc + settle_of(i);
        end
      end
    end else if (cyc == m_done_at[i]) begin
      if (m_rej[i]) begin
        e_rdata[i] = 4'd0; e_rovf[i] = 1'b0; e_err[i] = 1'b1;
      end else begin
        r = alu_fn(e_a[i], e_b[i], e_op[i]);
        e_rdata[i] = r[3:0]; e_rovf[i] = r[4]; e_err[i] = 1'b0;
      end
      e_done0[i] = !m_owner[i]; e_done1[i] = m_owner[i];
      m_busy[i] = 1'b0;
    end
  endfunction

  // Advance the model on every clock edge; reset it asynchronously with the DUTs.
  always @(posedge clock or negedge rst) begin
    if (!rst) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0);
      model_step(1);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every output of both instances against the model each cycle.
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("i%0d gnt0", i),  int'(gnt0[i]),  int'(e_gnt0[i]));
      chk($sformatf("i%0d gnt1", i),  int'(gnt1[i]),  int'(e_gnt1[i]));
      chk($sformatf("i%0d done0", i), int'(done0[i]), int'(e_done0[i]));
      chk($sformatf("i%0d done1", i), int'(done1[i]), int'(e_done1[i]));
      chk($sformatf("i%0d rdata", i), int'(rdata[i]), int'(e_rdata[i]));
      chk($sformatf("i%0d rovf", i),  int'(rovf[i]),  int'(e_rovf[i]));
      chk($sformatf("i%0d err", i),   int'(err[i]),   int'(e_err[i]));
      chk($sformatf("i%0d busy", i),  int'(busy[i]),  int'(m_busy[i]));
      chk($sformatf("i%0d alu_a", i), int'(alu_a[i]), int'(e_a[i]));
      chk($sformatf("i%0d alu_b", i), int'(alu_b[i]), int'(e_b[i]));
      chk($sformatf("i%0d alu_op", i), int'(alu_op[i]), int'(e_op[i]));
      chk($sformatf("i%0d gnt_excl", i), int'(gnt0[i] & gnt1[i]), 0);
      chk($sformatf("i%0d done_excl", i), int'(done0[i] & done1[i]), 0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic chk_reset_state(input int i, input string tag);
    chk({tag, " gnt0"}, int'(gnt0[i]), 0);
    chk({tag, " done0"}, int'(done0[i]), 0);
    chk({tag, " busy"}, int'(busy[i]), 0);
    chk({tag, " rdata"}, int'(rdata[i]), 0);
    chk({tag, " err"}, int'(err[i]), 0);
    chk({tag, " alu_a"}, int'(alu_a[i]), 0);
    chk({tag, " alu_op"}, int'(alu_op[i]), 15);
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req0[i] = 1'b0; req1[i] = 1'b0;
      a0[i] = 4'd0; b0[i] = 4'd0; op0[i] = 4'd0;
      a1[i] = 4'd0; b1[i] = 4'd0; op1[i] = 4'd0;
    end
    step();
    step();
    chk_reset_state(0, "reset s1");
    chk_reset_state(1, "reset s3");
    rst = 1'b1;
    step();

    // Single add on settle-1 instance: 3 + 4 = 7.
    req0[0] = 1'b1; a0[0] = 4'd3; b0[0] = 4'd4; op0[0] = 4'b0011;
    step();
    chk("add gnt0", int'(gnt0[0]), 1);
    chk("add alu_a", int'(alu_a[0]), 3);
    chk("add alu_b", int'(alu_b[0]), 4);
    chk("add alu_op", int'(alu_op[0]), 3);
    chk("add busy", int'(busy[0]), 1);
    req0[0] = 1'b0;
    step();
    chk("add done0", int'(done0[0]), 1);
    chk("add rdata", int'(rdata[0]), 7);
    chk("add rovf", int'(rovf[0]), 0);
    chk("add busy_done", int'(busy[0]), 0);
    step();
    chk("add hold rdata", int'(rdata[0]), 7);

    // Overflow capture: 7 + 1 = 8 with signed overflow.
    req1[0] = 1'b1; a1[0] = 4'd7; b1[0] = 4'd1; op1[0] = 4'b0011;
    step();
    chk("ovf gnt1", int'(gnt1[0]), 1);
    req1[0] = 1'b0;
    step();
    chk("ovf done1", int'(done1[0]), 1);
    chk("ovf rdata", int'(rdata[0]), 8);
    chk("ovf rovf", int'(rovf[0]), 1);
    step();

    // Illegal opcode: rejected after one edge, ALU drive untouched.
    req0[0] = 1'b1; a0[0] = 4'd9; b0[0] = 4'd9; op0[0] = 4'b1110;
    step();
    chk("ill gnt0", int'(gnt0[0]), 1);
    chk("ill alu_op", int'(alu_op[0]), 3);
    req0[0] = 1'b0;
    step();
    chk("ill done0", int'(done0[0]), 1);
    chk("ill err", int'(err[0]), 1);
    chk("ill rdata", int'(rdata[0]), 0);
    chk("ill rovf", int'(rovf[0]), 0);
    chk("ill alu_a", int'(alu_a[0]), 7);
    step();

    // Tie after reset: requester 0 first, then strict alternation.
    rst = 1'b0;
    step();
    rst = 1'b1;
    req0[0] = 1'b1; a0[0] = 4'd1; b0[0] = 4'd2; op0[0] = 4'b0011;
    req1[0] = 1'b1; a1[0] = 4'd5; b1[0] = 4'd3; op1[0] = 4'b0010;
    for (int t = 0; t < 8; t++) begin
      step();
      if (t % 4 == 0) begin
        chk($sformatf("tie gnt0 t%0d", t), int'(gnt0[0]), 1);
      end else if (t % 4 == 1) begin
        chk($sformatf("tie done0 t%0d", t), int'(done0[0]), 1);
        chk($sformatf("tie rdata0 t%0d", t), int'(rdata[0]), 3);
      end else if (t % 4 == 2) begin
        chk($sformatf("tie gnt1 t%0d", t), int'(gnt1[0]), 1);
      end else begin
        chk($sformatf("tie done1 t%0d", t), int'(done1[0]), 1);
        chk($sformatf("tie rdata1 t%0d", t), int'(rdata[0]), 2);
      end
    end
    req0[0] = 1'b0; req1[0] = 1'b0;
    step();

    // Settle latency 3: 6 - 2 = 4, operand change mid-op must not leak through.
    req0[1] = 1'b1; a0[1] = 4'd6; b0[1] = 4'd2; op0[1] = 4'b0010;
    step();
    chk("st gnt0", int'(gnt0[1]), 1);
    chk("st busy0", int'(busy[1]), 1);
    req0[1] = 1'b0; a0[1] = 4'd15; b0[1] = 4'd15;
    step();
    chk("st busy1", int'(busy[1]), 1);
    chk("st nodone1", int'(done0[1]), 0);
    chk("st alu_a", int'(alu_a[1]), 6);
    step();
    chk("st busy2", int'(busy[1]), 1);
    chk("st nodone2", int'(done0[1]), 0);
    step();
    chk("st done0", int'(done0[1]), 1);
    chk("st rdata", int'(rdata[1]), 4);
    chk("st busy3", int'(busy[1]), 0);
    step();

    // Reset mid-operation on the settle-3 instance.
    req0[1] = 1'b1; a0[1] = 4'd1; b0[1] = 4'd1; op0[1] = 4'b0011;
    step();
    chk("rm gnt0", int'(gnt0[1]), 1);
    req0[1] = 1'b0;
    req1[1] = 1'b1; a1[1] = 4'd2; b1[1] = 4'd3; op1[1] = 4'b0011;
    step();
    rst = 1'b0;
    #1;
    chk_reset_state(1, "rm async");
    step();
    chk("rm no done0", int'(done0[1]), 0);
    rst = 1'b1;
    step();
    chk("rm gnt1 first", int'(gnt1[1]), 1);
    chk("rm no gnt0", int'(gnt0[1]), 0);
    req1[1] = 1'b0;
    step();
    step();
    chk("rm early", int'(done1[1]), 0);
    step();
    chk("rm done1", int'(done1[1]), 1);
    chk("rm rdata", int'(rdata[1]), 5);
    chk("rm no stale done0", int'(done0[1]), 0);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencer and round-robin arbiter that shares one combinational 4-bit ALU (A, B, 4-bit opcode in; 4-bit result and overflow out) between two requesters. Each requester presents operands and an opcode with a req/gnt handshake. The block drives the ALU operand and opcode lines from registers, waits a programmable settle time, then captures result and overflow and returns them with a one-cycle done pulse. It sits between the ALU and its clients, for example the switch-input front end and an on-chip test sequencer.

## Interface
- SETTLE_CYCLES, 1: clock edges ALU inputs are held before capture; legal range 1–15.
- clock  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0, req1  in  1  request from requester 0 / 1.
- a0, b0, op0  in  4,4,4  operands/opcode of requester 0; sampled only at its grant edge.
- a1, b1, op1  in  4,4,4  same for requester 1.
- gnt0, gnt1  out  1  one-cycle pulse: request accepted, operands latched.
- done0, done1  out  1  one-cycle pulse: rdata/rovf/err valid for that requester.
- rdata  out  4  captured ALU result.
- rovf  out  1  captured ALU overflow.
- err  out  1  operation rejected (illegal opcode); qualified by done.
- busy  out  1  high in any state other than IDLE.
- alu_a, alu_b, alu_op  out  4,4,4  registered drive to the ALU.
- alu_result  in  4  ALU result.
- alu_overflow  in  1  ALU overflow.

## Operation
- States: IDLE, ISSUE, REJECT.
- IDLE, no request: hold state. Request pending: select a winner, pulse its gnt, record it as owner and last-granted.
  - Legal opcode (4'b0000–4'b1100): latch the winner's a/b/op into alu_a/alu_b/alu_op, clear settle counter, go to ISSUE.
  - Illegal opcode (4'b1101–4'b1111): go to REJECT; alu_* unchanged.
- Round-robin: only one requester asserting wins. Both asserting: the one not last-granted wins. After reset, last-granted = 1, so requester 0 wins the first tie.
- ISSUE: counter increments each edge. On the edge where counter = SETTLE_CYCLES-1:
  - rdata <= alu_result, rovf <= alu_overflow, err <= 0.
  - Pulse the owner's done.
  - Go to IDLE.
- REJECT: next edge sets rdata <= 0, rovf <= 0, err <= 1, pulses the owner's done, goes to IDLE.
- rdata, rovf, err hold until the next completion. alu_* hold their last values in IDLE.
- req is ignored outside IDLE. A requester drops req after seeing gnt. req still high when the block is back in IDLE counts as a new request.
- The ALU is treated as purely combinational. The block has no dependence on ALU internals.

## Timing
- Reset (rst low) forces, asynchronously:
  - state IDLE, counter 0, last-granted = 1.
  - gnt0/1 = 0, done0/1 = 0, busy = 0.
  - rdata = 0, rovf = 0, err = 0.
  - alu_a = 0, alu_b = 0, alu_op = 4'b1111 (ALU idles at 0).
- Grant at edge k: gnt high in cycle k..k+1; alu_* valid from edge k.
- Legal op: done high after edge k+SETTLE_CYCLES, for exactly one cycle, with rdata valid in that same cycle.
- Illegal op: done after edge k+1.
- busy high from edge k to the completion edge. The completion cycle itself shows busy = 0, so a new grant can occur at the next edge.
- Throughput: one operation per SETTLE_CYCLES+1 edges under continuous requests.
- Reset asserted mid-operation: the operation is discarded, no done is issued, and the owner must re-request.
- gnt and done are never high for both requesters in the same cycle. gnt and done for the same requester never coincide.

## Test plan
- Single add: req0, a0=3, b0=4, op0=4'b0011, SETTLE=1.
  - Required: gnt0 after edge k, alu_a=3/alu_b=4/alu_op=3.
  - Required: done0 after edge k+1 with rdata=7, rovf=0, err=0.
- Overflow capture: req1, a1=7, b1=1, op=4'b0011 -> done1 with rdata=8, rovf=1.
- Tie and fairness: after reset, req0 and req1 both held high with distinct ops.
  - Required: grants alternate 0,1,0,1.
  - Required: each done matches its own operands; no double grants.
- Illegal opcode: req0, op0=4'b1110 -> gnt0, then done0 one edge later with err=1, rdata=0, rovf=0, alu_op unchanged.
- Settle latency: SETTLE_CYCLES=3, req0 with a0=6, b0=2, op0=4'b0010.
  - Required: busy high for 3 edges, done0 exactly 3 edges after grant, rdata=4.
  - Required: an ALU input change in the middle of the op is not visible in rdata.
- Reset mid-op: SETTLE=3, grant req0, assert rst one cycle later.
  - Required: all outputs at reset values immediately, no done0.
  - Required: after release, a held req1 is granted first (last-granted reset to 1).
